// File: rtl/blake2_io_pkg.sv
// Shared encodings for the BLAKE2 host command interface: commands, FSM states
// and the two supported core block sizes.
package blake2_io_pkg;

    typedef enum logic [1:0] {
        CMD_CONF  = 2'd0,
        CMD_START = 2'd1,
        CMD_DATA  = 2'd2,
        CMD_ABORT = 2'd3
    } cmd_e;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CONF  = 3'd1;
    localparam logic [2:0] ST_READY = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_HASH  = 3'd4;

    localparam int unsigned B2S_BLOCK = 64;
    localparam int unsigned B2B_BLOCK = 128;

endpackage

// File: rtl/blake2_io_intf_p_if.sv
// Host-side bundle of the BLAKE2 command interface: command beats in,
// flow-control/error status and registered hash bytes out.
interface blake2_io_intf_p_if #(
    parameter int unsigned BPB = 1
) ();
    logic               valid_i;
    logic [1:0]         cmd_i;
    logic [8*BPB-1:0]   data_i;
    logic               ready_v_o;
    logic               err_o;
    logic               hash_v_o;
    logic [7:0]         hash_o;

    modport master (
        output valid_i, cmd_i, data_i,
        input  ready_v_o, err_o, hash_v_o, hash_o
    );

    modport slave (
        input  valid_i, cmd_i, data_i,
        output ready_v_o, err_o, hash_v_o, hash_o
    );
endinterface

// File: rtl/blake2_io_last_calc.sv
// Combinational last-block test: total = ll (+ one key block when kk != 0);
// a block is last once its end offset reaches total.
module blake2_io_last_calc #(
    parameter int unsigned BLOCK_BYTES = 64,
    parameter int unsigned LL_W        = 64,
    parameter int unsigned KK_W        = 6
) (
    input  logic [KK_W-1:0] kk_i,
    input  logic [LL_W-1:0] ll_i,
    input  logic [LL_W-1:0] blk_cnt_i,
    output logic            last_o
);
    localparam int unsigned    TW  = LL_W + 1;
    localparam logic [TW-1:0]  BLK = TW'(BLOCK_BYTES);
    localparam logic [TW-1:0]  ONE = TW'(1);

    logic [TW-1:0] total;
    logic [TW-1:0] blk_end;

    always_comb begin
        total   = {1'b0, ll_i} + ((kk_i != '0) ? BLK : '0);
        blk_end = ({1'b0, blk_cnt_i} + ONE) * BLK;
        last_o  = (blk_end >= total);
    end
endmodule

// File: rtl/blake2_io_intf_p.sv
// Parametrised BLAKE2s/BLAKE2b host interface: decodes commands, captures
// kk/nn/ll, streams padded blocks BPB bytes per beat and relays hash bytes.
module blake2_io_intf_p
    import blake2_io_pkg::*;
#(
    parameter int unsigned BPB         = 1,
    parameter int unsigned BLOCK_BYTES = B2S_BLOCK,
    parameter int unsigned LL_W        = 64,
    parameter int unsigned KK_W        = 6
) (
    input  logic                             clk,
    input  logic                             nreset,
    input  logic                             en_i,
    blake2_io_intf_p_if.slave                host,
    input  logic [1:0]                       output_mode_i,
    input  logic                             ready_v_i,
    input  logic                             hash_v_i,
    input  logic [7:0]                       hash_i,
    output logic [KK_W-1:0]                  kk_o,
    output logic [KK_W-1:0]                  nn_o,
    output logic [LL_W-1:0]                  ll_o,
    output logic                             data_v_o,
    output logic [8*BPB-1:0]                 data_o,
    output logic [$clog2(BLOCK_BYTES)-1:0]   data_idx_o,
    output logic                             block_first_o,
    output logic                             block_last_o,
    output logic                             slow_output_o
);
    localparam int unsigned         IDX_W     = $clog2(BLOCK_BYTES);
    localparam int unsigned         CW        = $clog2(LL_W/8 + 2);
    localparam logic [CW-1:0]       CONF_LAST = CW'(LL_W/8 + 1);
    localparam logic [IDX_W-1:0]    BPB_STEP  = IDX_W'(BPB);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(BLOCK_BYTES - BPB);

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    conf_cnt_q, conf_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LL_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic             first_q, first_d;
    logic [KK_W-1:0]  hash_cnt_q, hash_cnt_d;
    logic [KK_W-1:0]  kk_q, kk_d, nn_q, nn_d;
    logic [LL_W-1:0]  ll_q, ll_d;
    logic             err_q, err_d, ready_v_q, ready_v_d;
    logic             hash_v_q, hash_v_d, slow_q, slow_d;
    logic [7:0]       hash_q, hash_d;
    logic             data_v_q, data_v_d;
    logic [8*BPB-1:0] data_q, data_d;
    logic [IDX_W-1:0] data_idx_q, data_idx_d;
    logic             block_first_q, block_first_d, block_last_q, block_last_d;
    logic             is_last;

    blake2_io_last_calc #(
        .BLOCK_BYTES (BLOCK_BYTES),
        .LL_W        (LL_W),
        .KK_W        (KK_W)
    ) u_last_calc (
        .kk_i      (kk_q),
        .ll_i      (ll_q),
        .blk_cnt_i (blk_cnt_q),
        .last_o    (is_last)
    );

    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        state_d       = state_q;       conf_cnt_d    = conf_cnt_q;
        idx_d         = idx_q;         blk_cnt_d     = blk_cnt_q;
        first_d       = first_q;       hash_cnt_d    = hash_cnt_q;
        kk_d          = kk_q;          nn_d          = nn_q;
        ll_d          = ll_q;          err_d         = err_q;
        ready_v_d     = ready_v_q;     hash_v_d      = hash_v_q;
        hash_d        = hash_q;        slow_d        = slow_q;
        data_v_d      = data_v_q;      data_d        = data_q;
        data_idx_d    = data_idx_q;    block_first_d = block_first_q;
        block_last_d  = block_last_q;

        if (en_i) begin
            data_v_d  = 1'b0;
            hash_v_d  = hash_v_i;
            hash_d    = hash_i;
            slow_d    = (output_mode_i != 2'd0);
            ready_v_d = ready_v_i & (state_q == ST_DATA) & (idx_q == '0);

            if (host.valid_i) begin
                if (host.cmd_i == CMD_ABORT) begin
                    state_d    = ST_IDLE;
                    conf_cnt_d = '0;
                    idx_d      = '0;
                    blk_cnt_d  = '0;
                    hash_cnt_d = '0;
                end else begin
                    case (state_q)
                        ST_IDLE, ST_READY: begin
                            if (host.cmd_i == CMD_CONF) begin
                                state_d    = ST_CONF;
                                conf_cnt_d = '0;
                                err_d      = 1'b0;
                            end else if (host.cmd_i == CMD_START) begin
                                state_d   = ST_DATA;
                                idx_d     = '0;
                                blk_cnt_d = '0;
                                first_d   = 1'b1;
                            end
                        end
                        ST_CONF: begin
                            if (host.cmd_i == CMD_CONF) begin
                                if (conf_cnt_q == CW'(0)) kk_d = KK_W'(host.data_i[7:0]);
                                if (conf_cnt_q == CW'(1)) nn_d = KK_W'(host.data_i[7:0]);
                                for (int b = 0; b < LL_W/8; b++) begin
                                    if (conf_cnt_q == CW'(b + 2)) ll_d[8*b +: 8] = host.data_i[7:0];
                                end
                                if (conf_cnt_q == CONF_LAST) begin
                                    state_d    = ST_READY;
                                    conf_cnt_d = '0;
                                end else begin
                                    conf_cnt_d = conf_cnt_q + CW'(1);
                                end
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        ST_DATA: begin
                            if (host.cmd_i == CMD_DATA) begin
                                // A new block may only open while the core is ready.
                                if (idx_q != '0 || ready_v_i) begin
                                    data_v_d      = 1'b1;
                                    data_d        = host.data_i;
                                    data_idx_d    = idx_q;
                                    block_first_d = first_q;
                                    block_last_d  = is_last;
                                    if (idx_q == LAST_IDX) begin
                                        idx_d     = '0;
                                        first_d   = 1'b0;
                                        blk_cnt_d = blk_cnt_q + LL_W'(1);
                                        if (is_last) state_d = ST_HASH;
                                    end else begin
                                        idx_d = idx_q + BPB_STEP;
                                    end
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                        end
                        ST_HASH: begin
                            if (host.cmd_i == CMD_DATA || host.cmd_i == CMD_START) err_d = 1'b1;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end

            // Digest bytes are counted off the core so the config can be reused.
            if (state_q == ST_HASH && state_d == ST_HASH) begin
                if (hash_v_i) hash_cnt_d = hash_cnt_q + KK_W'(1);
                if (nn_q == '0 || (hash_v_i && (hash_cnt_q + KK_W'(1)) == nn_q)) begin
                    state_d    = ST_READY;
                    hash_cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        // NOTE: state updates use <= so all flops sample pre-edge values together.
        if (!nreset) begin
            state_q       <= ST_IDLE;  conf_cnt_q    <= '0;
            idx_q         <= '0;       blk_cnt_q     <= '0;
            first_q       <= 1'b0;     hash_cnt_q    <= '0;
            kk_q          <= '0;       nn_q          <= '0;
            ll_q          <= '0;       err_q         <= 1'b0;
            ready_v_q     <= 1'b0;     hash_v_q      <= 1'b0;
            hash_q        <= '0;       slow_q        <= 1'b0;
            data_v_q      <= 1'b0;     data_q        <= '0;
            data_idx_q    <= '0;       block_first_q <= 1'b0;
            block_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;  conf_cnt_q    <= conf_cnt_d;
            idx_q         <= idx_d;    blk_cnt_q     <= blk_cnt_d;
            first_q       <= first_d;  hash_cnt_q    <= hash_cnt_d;
            kk_q          <= kk_d;     nn_q          <= nn_d;
            ll_q          <= ll_d;     err_q         <= err_d;
            ready_v_q     <= ready_v_d; hash_v_q     <= hash_v_d;
            hash_q        <= hash_d;   slow_q        <= slow_d;
            data_v_q      <= data_v_d; data_q        <= data_d;
            data_idx_q    <= data_idx_d; block_first_q <= block_first_d;
            block_last_q  <= block_last_d;
        end
    end

    assign host.ready_v_o = ready_v_q;
    assign host.err_o     = err_q;
    assign host.hash_v_o  = hash_v_q;
    assign host.hash_o    = hash_q;
    assign kk_o           = kk_q;
    assign nn_o           = nn_q;
    assign ll_o           = ll_q;
    assign data_v_o       = data_v_q;
    assign data_o         = data_q;
    assign data_idx_o     = data_idx_q;
    assign block_first_o  = block_first_q;
    assign block_last_o   = block_last_q;
    assign slow_output_o  = slow_q;
endmodule

// File: tb/tb_blake2_io_intf_p.sv
// Directed bench for blake2_io_intf_p: a BLAKE2s byte-wide instance and a
// BLAKE2b 4-byte-beat instance driven from one scenario sequence.
module tb_blake2_io_intf_p;
    import blake2_io_pkg::*;

    logic clk = 1'b0;
    logic nreset, en_i, ready_v_i, hash_v_i;
    logic [1:0] output_mode_i;
    logic [7:0] hash_i;

    logic [5:0]  kk_o, nn_o;
    logic [63:0] ll_o;
    logic        data_v_o, block_first_o, block_last_o, slow_output_o;
    logic [7:0]  data_o;
    logic [5:0]  data_idx_o;

    logic [5:0]  kk4_o, nn4_o;
    logic [63:0] ll4_o;
    logic        data_v4_o, block_first4_o, block_last4_o, slow_output4_o;
    logic [31:0] data4_o;
    logic [6:0]  data_idx4_o;

    int vecs = 0;
    int miscompares = 0;

    blake2_io_intf_p_if #(.BPB(1)) h1 ();
    blake2_io_intf_p_if #(.BPB(4)) h4 ();

    blake2_io_intf_p #(.BPB(1), .BLOCK_BYTES(64), .LL_W(64), .KK_W(6)) u_dut (
        .clk (clk), .nreset (nreset), .en_i (en_i), .host (h1.slave),
        .output_mode_i (output_mode_i), .ready_v_i (ready_v_i),
        .hash_v_i (hash_v_i), .hash_i (hash_i),
        .kk_o (kk_o), .nn_o (nn_o), .ll_o (ll_o),
        .data_v_o (data_v_o), .data_o (data_o), .data_idx_o (data_idx_o),
        .block_first_o (block_first_o), .block_last_o (block_last_o),
        .slow_output_o (slow_output_o)
    );

    blake2_io_intf_p #(.BPB(4), .BLOCK_BYTES(128), .LL_W(64), .KK_W(6)) u_dut4 (
        .clk (clk), .nreset (nreset), .en_i (en_i), .host (h4.slave),
        .output_mode_i (output_mode_i), .ready_v_i (ready_v_i),
        .hash_v_i (hash_v_i), .hash_i (hash_i),
        .kk_o (kk4_o), .nn_o (nn4_o), .ll_o (ll4_o),
        .data_v_o (data_v4_o), .data_o (data4_o), .data_idx_o (data_idx4_o),
        .block_first_o (block_first4_o), .block_last_o (block_last4_o),
        .slow_output_o (slow_output4_o)
    );

    always #5 clk = ~clk;

    // One host beat: drive after the falling edge, sample 1 ns after the rising edge.
    task automatic send1(input logic [1:0] cmd, input logic [7:0] data);
        @(negedge clk);
        h1.valid_i = 1'b1; h1.cmd_i = cmd; h1.data_i = data;
        @(posedge clk); #1;
        h1.valid_i = 1'b0;
    endtask

    task automatic send4(input logic [1:0] cmd, input logic [31:0] data);
        @(negedge clk);
        h4.valid_i = 1'b1; h4.cmd_i = cmd; h4.data_i = data;
        @(posedge clk); #1;
        h4.valid_i = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk); @(posedge clk); #1;
    endtask

    task automatic conf1(input logic [7:0] kk, input logic [7:0] nn, input logic [63:0] ll);
        send1(CMD_CONF, 8'h00);
        send1(CMD_CONF, kk);
        send1(CMD_CONF, nn);
        for (int b = 0; b < 8; b++) send1(CMD_CONF, ll[8*b +: 8]);
    endtask

    task automatic test_reset();
        nreset = 1'b0; en_i = 1'b1; ready_v_i = 1'b1; hash_v_i = 1'b0; hash_i = 8'h00;
        output_mode_i = 2'd0;
        h1.valid_i = 1'b0; h1.cmd_i = 2'd0; h1.data_i = '0;
        h4.valid_i = 1'b0; h4.cmd_i = 2'd0; h4.data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        vecs++; if ({data_v_o, h1.ready_v_o, h1.err_o, h1.hash_v_o} !== 4'b0) begin
            miscompares++; $display("FAIL reset_flags: got %b want 0000", {data_v_o, h1.ready_v_o, h1.err_o, h1.hash_v_o}); end
        vecs++; if ({kk_o, nn_o, ll_o} !== 76'd0) begin
            miscompares++; $display("FAIL reset_conf: got %h want 0", {kk_o, nn_o, ll_o}); end
        vecs++; if ({data_o, data_idx_o, block_first_o, block_last_o, slow_output_o, h1.hash_o} !== '0) begin
            miscompares++; $display("FAIL reset_data: got %h want 0", {data_o, data_idx_o, block_first_o, block_last_o, slow_output_o, h1.hash_o}); end
        vecs++; if ({data_v4_o, data4_o, data_idx4_o, h4.err_o} !== '0) begin
            miscompares++; $display("FAIL reset_dut4: got %h want 0", {data_v4_o, data4_o, data_idx4_o, h4.err_o}); end
        @(negedge clk); nreset = 1'b1;
    endtask

    task automatic test_single_block();
        logic [16:0] got, exp;
        conf1(8'h00, 8'h20, 64'd3);
        vecs++; if ({kk_o, nn_o, ll_o, h1.err_o} !== {6'd0, 6'h20, 64'd3, 1'b0}) begin
            miscompares++; $display("FAIL conf_load: got %h want %h", {kk_o, nn_o, ll_o, h1.err_o}, {6'd0, 6'h20, 64'd3, 1'b0}); end
        send1(CMD_START, 8'h00);
        idle_cycle();
        vecs++; if (h1.ready_v_o !== 1'b1) begin
            miscompares++; $display("FAIL ready_after_start: got %b want 1", h1.ready_v_o); end
        for (int i = 0; i < 64; i++) begin
            send1(CMD_DATA, 8'(i) ^ 8'hA5);
            got = {data_v_o, data_idx_o, data_o, block_first_o, block_last_o};
            exp = {1'b1, 6'(i), 8'(i) ^ 8'hA5, 1'b1, 1'b1};
            vecs++; if (got !== exp) begin
                miscompares++; $display("FAIL single_beat%0d: got %h want %h", i, got, exp); end
        end
        for (int j = 0; j < 32; j++) begin
            @(negedge clk); hash_v_i = 1'b1; hash_i = 8'h40 + 8'(j);
            @(posedge clk); #1;
            vecs++; if ({h1.hash_v_o, h1.hash_o} !== {1'b1, 8'h40 + 8'(j)}) begin
                miscompares++; $display("FAIL hash_byte%0d: got %h want %h", j, {h1.hash_v_o, h1.hash_o}, {1'b1, 8'h40 + 8'(j)}); end
        end
        @(negedge clk); hash_v_i = 1'b0;
        @(posedge clk); #1;
        vecs++; if (h1.hash_v_o !== 1'b0) begin
            miscompares++; $display("FAIL hash_v_drop: got %b want 0", h1.hash_v_o); end
        send1(CMD_START, 8'h00);
        idle_cycle();
        vecs++; if ({h1.ready_v_o, h1.err_o} !== 2'b10) begin
            miscompares++; $display("FAIL back_to_ready: got %b want 10", {h1.ready_v_o, h1.err_o}); end
        send1(CMD_ABORT, 8'h00);
    endtask

    task automatic test_two_blocks();
        logic [8:0] got, exp;
        conf1(8'd16, 8'd32, 64'd64);
        send1(CMD_START, 8'h00);
        for (int blk = 0; blk < 2; blk++) begin
            for (int i = 0; i < 64; i++) begin
                send1(CMD_DATA, 8'(i));
                got = {data_v_o, data_idx_o, block_first_o, block_last_o};
                exp = {1'b1, 6'(i), blk == 0, blk == 1};
                vecs++; if (got !== exp) begin
                    miscompares++; $display("FAIL two_blk%0d_beat%0d: got %h want %h", blk, i, got, exp); end
            end
        end
        send1(CMD_ABORT, 8'h00);
        vecs++; if ({kk_o, nn_o, ll_o} !== {6'd16, 6'd32, 64'd64}) begin
            miscompares++; $display("FAIL abort_keeps_conf: got %h want %h", {kk_o, nn_o, ll_o}, {6'd16, 6'd32, 64'd64}); end
    endtask

    task automatic test_empty_message();
        logic [8:0] got, exp;
        conf1(8'd0, 8'd32, 64'd0);
        send1(CMD_START, 8'h00);
        for (int i = 0; i < 64; i++) begin
            send1(CMD_DATA, 8'h00);
            got = {data_v_o, data_idx_o, block_first_o, block_last_o};
            exp = {1'b1, 6'(i), 1'b1, 1'b1};
            vecs++; if (got !== exp) begin
                miscompares++; $display("FAIL empty_beat%0d: got %h want %h", i, got, exp); end
        end
        send1(CMD_DATA, 8'h55);
        vecs++; if ({data_v_o, h1.err_o} !== 2'b01) begin
            miscompares++; $display("FAIL data_in_hash: got %b want 01", {data_v_o, h1.err_o}); end
        send1(CMD_ABORT, 8'h00);
    endtask

    task automatic test_drop_and_abort();
        logic [8:0] got, exp;
        conf1(8'd0, 8'd32, 64'd3);
        vecs++; if (h1.err_o !== 1'b0) begin
            miscompares++; $display("FAIL err_clear_on_conf: got %b want 0", h1.err_o); end
        send1(CMD_START, 8'h00);
        ready_v_i = 1'b0;
        send1(CMD_DATA, 8'h11);
        vecs++; if ({data_v_o, h1.err_o} !== 2'b01) begin
            miscompares++; $display("FAIL drop_not_ready: got %b want 01", {data_v_o, h1.err_o}); end
        ready_v_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send1(CMD_DATA, 8'(i));
            vecs++; if ({data_v_o, data_idx_o} !== {1'b1, 6'(i)}) begin
                miscompares++; $display("FAIL pre_abort_beat%0d: got %h want %h", i, {data_v_o, data_idx_o}, {1'b1, 6'(i)}); end
        end
        vecs++; if (h1.err_o !== 1'b1) begin
            miscompares++; $display("FAIL err_sticky: got %b want 1", h1.err_o); end
        send1(CMD_ABORT, 8'h00);
        vecs++; if ({data_v_o, kk_o, nn_o, ll_o} !== {1'b0, 6'd0, 6'd32, 64'd3}) begin
            miscompares++; $display("FAIL abort_state: got %h want %h", {data_v_o, kk_o, nn_o, ll_o}, {1'b0, 6'd0, 6'd32, 64'd3}); end
        send1(CMD_START, 8'h00);
        for (int i = 0; i < 64; i++) begin
            send1(CMD_DATA, 8'(i));
            got = {data_v_o, data_idx_o, block_first_o, block_last_o};
            exp = {1'b1, 6'(i), 1'b1, 1'b1};
            vecs++; if (got !== exp) begin
                miscompares++; $display("FAIL restart_beat%0d: got %h want %h", i, got, exp); end
        end
        send1(CMD_ABORT, 8'h00);
        send1(CMD_CONF, 8'h00);
        vecs++; if (h1.err_o !== 1'b0) begin
            miscompares++; $display("FAIL err_clear_first_conf: got %b want 0", h1.err_o); end
        send1(CMD_ABORT, 8'h00);
    endtask

    task automatic test_enable();
        send1(CMD_START, 8'h00);
        for (int i = 0; i < 5; i++) send1(CMD_DATA, 8'(i));
        idle_cycle();
        en_i = 1'b0; output_mode_i = 2'd1;
        send1(CMD_DATA, 8'hEE);
        vecs++; if ({data_v_o, slow_output_o} !== 2'b00) begin
            miscompares++; $display("FAIL enable_low_hold: got %b want 00", {data_v_o, slow_output_o}); end
        en_i = 1'b1;
        send1(CMD_DATA, 8'h77);
        vecs++; if ({data_v_o, data_idx_o, data_o, slow_output_o} !== {1'b1, 6'd5, 8'h77, 1'b1}) begin
            miscompares++; $display("FAIL enable_resume: got %h want %h", {data_v_o, data_idx_o, data_o, slow_output_o}, {1'b1, 6'd5, 8'h77, 1'b1}); end
    endtask

    task automatic test_reset_mid();
        #2 nreset = 1'b0;
        #1;
        vecs++; if ({data_v_o, data_idx_o, data_o, block_first_o, block_last_o, nn_o, ll_o, slow_output_o} !== '0) begin
            miscompares++; $display("FAIL async_reset_mid: got %h want 0", {data_v_o, data_idx_o, data_o, block_first_o, block_last_o, nn_o, ll_o, slow_output_o}); end
        output_mode_i = 2'd0;
        @(negedge clk); nreset = 1'b1;
    endtask

    task automatic test_bpb4_blake2b();
        logic [41:0] got, exp;
        logic [6:0]  idx;
        send4(CMD_CONF, 32'h0);
        send4(CMD_CONF, 32'h0);
        send4(CMD_CONF, 32'd32);
        send4(CMD_CONF, 32'hC8);
        for (int b = 1; b < 8; b++) send4(CMD_CONF, 32'h0);
        vecs++; if ({kk4_o, nn4_o, ll4_o} !== {6'd0, 6'd32, 64'd200}) begin
            miscompares++; $display("FAIL b2b_conf: got %h want %h", {kk4_o, nn4_o, ll4_o}, {6'd0, 6'd32, 64'd200}); end
        send4(CMD_START, 32'h0);
        for (int blk = 0; blk < 2; blk++) begin
            for (int i = 0; i < 32; i++) begin
                idx = 7'(4 * i);
                send4(CMD_DATA, {8'(idx) + 8'd3, 8'(idx) + 8'd2, 8'(idx) + 8'd1, 8'(idx)});
                got = {data_v4_o, data_idx4_o, data4_o, block_first4_o, block_last4_o};
                exp = {1'b1, idx, 8'(idx) + 8'd3, 8'(idx) + 8'd2, 8'(idx) + 8'd1, 8'(idx), blk == 0, blk == 1};
                vecs++; if (got !== exp) begin
                    miscompares++; $display("FAIL b2b_blk%0d_beat%0d: got %h want %h", blk, i, got, exp); end
            end
        end
        send4(CMD_ABORT, 32'h0);
        vecs++; if ({data_v4_o, h4.err_o} !== 2'b00) begin
            miscompares++; $display("FAIL b2b_end: got %b want 00", {data_v4_o, h4.err_o}); end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_two_blocks();
        test_empty_message();
        test_drop_and_abort();
        test_enable();
        test_reset_mid();
        test_bpb4_blake2b();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
